// File: rtl/counter_pkg.sv
// counter_pkg: shared types and default width for the up/down counter family
package counter_pkg;
  localparam int COUNTER_WIDTH = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_e;
endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with terminal-count pulse, one-shot or periodic reload
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  timer_state_e state, state_next;
  logic [WIDTH-1:0] reload_val, count_next, reload_next;
  logic ld, step, term;
  // load and enable together is a conflicting request and acts as neither
  assign ld   = load & ~enable;
  assign step = enable & ~load & (state != DONE) & (count != '0);
  assign term = step & (count == WIDTH'(1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = ld ? IDLE : term ? (auto_reload ? RUN : DONE) : step ? RUN : state;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_comb begin
    count_next  = ld ? data : term ? (auto_reload ? reload_val : '0) : step ? count - 1'b1 : count;
    reload_next = ld ? data : reload_val;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count      <= '0;
      reload_val <= '0;
      tc         <= 1'b0;
    end else begin
      count      <= count_next;
      reload_val <= reload_next;
      tc         <= term;
    end
endmodule
